// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer-width formula and Gray/binary conversion.
// The conversion functions work on zero-extended words of up to GRAY_MAX_W bits,
// so any pointer width up to that limit can use them (cast the result back).
package fifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  // Pointer width for a given memory depth: address bits plus one wrap bit
  function automatic int unsigned fifo_ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Binary to reflected Gray code
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code to binary (prefix XOR from the MSB down)
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side output stream of the async FIFO (first-word-fall-through valid/ready).
// Optional macro: FIFO_RD_ALMOST_EMPTY_EN adds the R_almost_empty flag.
interface fifo_rd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 4
);

  logic [DATA_WIDTH-1:0] R_dout;
  logic                  R_valid;
  logic                  R_ready;
  logic                  R_empty;
  logic [PTR_WIDTH-1:0]  R_level;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic                  R_almost_empty;

  modport master (
    output R_dout, R_valid, R_empty, R_level, R_almost_empty,
    input  R_ready
  );

  modport slave (
    input  R_dout, R_valid, R_empty, R_level, R_almost_empty,
    output R_ready
  );
`else
  modport master (
    output R_dout, R_valid, R_empty, R_level,
    input  R_ready
  );

  modport slave (
    input  R_dout, R_valid, R_empty, R_level,
    output R_ready
  );
`endif

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it.
module fifo_gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_c
);

  // Per-bit prefix XOR from the MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_c[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO (R_clk domain only).
// Keeps binary/Gray read pointers, drives the memory read address, and turns the
// memory into a first-word-fall-through stream with a registered output word.
// Empty and occupancy come from the write Gray pointer already synchronised here.
// Optional macro: FIFO_RD_ALMOST_EMPTY_EN adds R_almost_empty (threshold AE_THRESH).
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 8,
  parameter int unsigned PTR_WIDTH  = fifo_ptr_width(MEM_DEPTH),
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  R_clk,
  input  logic                  R_rst,
  input  logic [PTR_WIDTH-1:0]  WQ2_gptr,
  input  logic [DATA_WIDTH-1:0] R_data_mem,
  output logic [PTR_WIDTH-2:0]  R_addr,
  output logic [PTR_WIDTH-1:0]  R_gptr,
  fifo_rd_ctrl_if.master        rd
);

  localparam int unsigned LVL_W = PTR_WIDTH + 1;

  // Elaboration-time parameter sanity
  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 ||
      PTR_WIDTH != fifo_ptr_width(MEM_DEPTH) || AE_THRESH > MEM_DEPTH + 1) begin : g_bad_params
    $error("fifo_rd_ctrl: illegal MEM_DEPTH/PTR_WIDTH/AE_THRESH combination");
  end

  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] wbin_c;
  logic [PTR_WIDTH-1:0] rbin_next_c;
  logic [PTR_WIDTH-1:0] level_next_c;
  logic                 mem_nonempty_c;
  logic                 take_c;
  logic                 load_c;
  logic                 valid_next_c;

  // Synchronised write pointer back to binary for occupancy arithmetic
  fifo_gray2bin #(
    .WIDTH (PTR_WIDTH)
  ) u_wq2_gray2bin (
    .gray  (WQ2_gptr),
    .bin_c (wbin_c)
  );

  assign R_addr = rbin[PTR_WIDTH-2:0];

  // Load/take decision and next-state values for pointer, valid and level
  always_comb begin
    mem_nonempty_c = 1'b0;
    take_c         = 1'b0;
    load_c         = 1'b0;
    rbin_next_c    = rbin;
    valid_next_c   = rd.R_valid;
    level_next_c   = '0;

    mem_nonempty_c = (R_gptr != WQ2_gptr);
    take_c         = rd.R_valid && rd.R_ready;
    load_c         = mem_nonempty_c && (!rd.R_valid || take_c);

    if (load_c) begin
      rbin_next_c  = rbin + PTR_WIDTH'(1);
      valid_next_c = 1'b1;
    end else if (take_c) begin
      valid_next_c = 1'b0;
    end

    level_next_c = wbin_c - rbin_next_c;
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic ae_next_c;

  // Almost-empty counts the output register word as well as the memory words
  always_comb begin
    ae_next_c = 1'b1;
    ae_next_c = (LVL_W'(level_next_c) + LVL_W'(valid_next_c)) <= LVL_W'(AE_THRESH);
  end
`endif

  // Pointer and output register state; reset discards any held word
  always_ff @(posedge R_clk or negedge R_rst) begin
    if (!R_rst) begin
      rbin       <= '0;
      R_gptr     <= '0;
      rd.R_dout  <= '0;
      rd.R_valid <= 1'b0;
      rd.R_empty <= 1'b1;
      rd.R_level <= '0;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      rd.R_almost_empty <= 1'b1;
`endif
    end else begin
      rbin       <= rbin_next_c;
      R_gptr     <= PTR_WIDTH'(bin2gray(GRAY_MAX_W'(rbin_next_c)));
      rd.R_valid <= valid_next_c;
      rd.R_empty <= !valid_next_c;
      rd.R_level <= level_next_c;
      if (load_c) begin
        rd.R_dout <= R_data_mem;
      end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      rd.R_almost_empty <= ae_next_c;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios then randomized traffic,
// compared against a queue-based model of the FIFO contents and output word.
module tb_fifo_rd_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 4;
  localparam int unsigned AE    = 2;

  logic           R_clk;
  logic           R_rst;
  logic [PW-1:0]  WQ2_gptr;
  logic [DW-1:0]  R_data_mem;
  logic [PW-2:0]  R_addr;
  logic [PW-1:0]  R_gptr;
  logic [DW-1:0]  mem [DEPTH];

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) rd_if ();

  fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .PTR_WIDTH  (PW),
    .AE_THRESH  (AE)
  ) dut (
    .R_clk      (R_clk),
    .R_rst      (R_rst),
    .WQ2_gptr   (WQ2_gptr),
    .R_data_mem (R_data_mem),
    .R_addr     (R_addr),
    .R_gptr     (R_gptr),
    .rd         (rd_if)
  );

  assign R_data_mem = mem[R_addr];

  initial R_clk = 1'b0;
  always #5 R_clk = ~R_clk;

  int n_tests;
  int n_fail;

  // Reference model: words written, words pulled into the output register,
  // words still in memory, and the output register itself
  int            wcnt;
  int            rcnt;
  logic [DW-1:0] mq[$];
  logic          m_valid;
  logic [DW-1:0] m_data;

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("valid", 32'(rd_if.R_valid), 32'(m_valid));
    check("empty", 32'(rd_if.R_empty), 32'(!m_valid));
    check("dout",  32'(rd_if.R_dout),  32'(m_data));
    check("level", 32'(rd_if.R_level), 32'(mq.size()));
    check("gptr",  32'(R_gptr),        32'(gray_of(rcnt)));
    check("addr",  32'(R_addr),        32'(rcnt % int'(DEPTH)));
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("almost_empty", 32'(rd_if.R_almost_empty),
          32'((mq.size() + int'(m_valid)) <= int'(AE)));
`endif
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[(PW-1)'(wcnt)] = d;
    mq.push_back(d);
    wcnt++;
    WQ2_gptr = gray_of(wcnt);
  endtask

  // One clock: drive ready, advance the model at the edge, check at the falling edge
  task automatic step(input logic rdy);
    logic take;
    logic load;
    rd_if.R_ready = rdy;
    @(posedge R_clk);
    take = m_valid && rdy;
    load = (mq.size() > 0) && (!m_valid || take);
    if (load) begin
      m_data  = mq.pop_front();
      m_valid = 1'b1;
      rcnt++;
    end else if (take) begin
      m_valid = 1'b0;
    end
    @(negedge R_clk);
    check_outputs();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic apply_reset();
    R_rst = 1'b0;
    #1;
    m_valid  = 1'b0;
    m_data   = '0;
    mq.delete();
    rcnt     = 0;
    wcnt     = 0;
    WQ2_gptr = '0;
    check_outputs();
    @(negedge R_clk);
    @(negedge R_clk);
    R_rst = 1'b1;
  endtask

  initial begin
    int free;
    int n;
    n_tests       = 0;
    n_fail        = 0;
    R_rst         = 1'b1;
    rd_if.R_ready = 1'b0;
    WQ2_gptr      = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    #2;
    apply_reset();
    step(1'b0);

    // Single word, consumer stalled, then consumed
    push_word(8'hA1);
    step(1'b0);
    check("a1_dout", 32'(rd_if.R_dout), 32'h0000_00A1);
    check("a1_gptr", 32'(R_gptr), 32'd1);
    step(1'b0);
    step(1'b0);
    check("a1_hold", 32'(rd_if.R_dout), 32'h0000_00A1);
    step(1'b1);
    step(1'b1);

    // Burst of four with ready held high
    apply_reset();
    for (int i = 0; i < 4; i++) push_word(DW'(8'h10 + i));
    repeat (6) step(1'b1);
    check("burst_gptr", 32'(R_gptr), 32'd6);
    check("burst_valid", 32'(rd_if.R_valid), 32'd0);

    // Pointer wrap: advance read pointer to 14, then read addresses 6,7,0,1
    apply_reset();
    repeat (2) begin
      repeat (7) push_word(DW'($urandom));
      repeat (9) step(1'b1);
    end
    check("wrap_addr", 32'(R_addr), 32'd6);
    for (int i = 0; i < 4; i++) push_word(DW'(8'hC0 + i));
    repeat (6) step(1'b1);
    check("wrap_gptr", 32'(R_gptr), 32'd3);

    // Multi-entry jump of the write pointer, then reset with a word held
    apply_reset();
    repeat (4) push_word(DW'($urandom));
    step(1'b0);
    check("pre_rst_valid", 32'(rd_if.R_valid), 32'd1);
    check("pre_rst_level", 32'(rd_if.R_level), 32'd3);
    apply_reset();

    // Randomized traffic with one reset in the middle
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) apply_reset();
      free = int'(DEPTH) - (wcnt - rcnt);
      n = int'($urandom_range(0, 3));
      if (n > free) n = free;
      for (int k = 0; k < n; k++) push_word(DW'($urandom));
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
